input_image_loader: RTL

- Writer-side counterpart of the convolution datapath's input-SRAM reader.
- Accepts image dimensions plus a serial 1-bit pixel stream (valid/ready), packs pixels into 16-bit row words and writes them into input SRAM.
- Memory format per image: nrows word, ncols word, then one word per row, with column c at bit c.
- Images are packed back to back; the finish command writes the terminator word that ends the convolution run.

---
 rtl/input_image_loader_pkg.sv | 28 ++
 rtl/input_image_loader_if.sv | 24 ++
 rtl/input_image_loader_row_packer.sv | 48 ++++
 rtl/input_image_loader.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/input_image_loader_pkg.sv
// Shared definitions for the input-SRAM loader and the convolution controller
// that reads the same image layout back.
package input_image_loader_pkg;

    localparam int IIL_DATA_W = 16;
    localparam int IIL_ADDR_W = 12;
    localparam logic [IIL_DATA_W-1:0] IIL_TERM_WORD = 16'h00FF;

    // Per-image layout relative to the image's first word
    localparam int HDR_NROWS_OFS = 0;
    localparam int HDR_NCOLS_OFS = 1;
    localparam int HDR_ROW0_OFS  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_R,
        ST_HDR_C,
        ST_STREAM,
        ST_ROW_WR,
        ST_DONE,
        ST_TERM
    } loader_state_e;

    function automatic logic dim_ok(input logic [4:0] d);
        return (d != 5'd0) && (d <= 5'd16);
    endfunction

endpackage

// File: rtl/input_image_loader_if.sv
// Pixel stream and SRAM write bus of the loader; slave is the loader side.
interface input_image_loader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              pix_valid;
    logic              pix_data;
    logic              pix_ready;
    logic [ADDR_W-1:0] loader_sram_write_address;
    logic [DATA_W-1:0] loader_sram_write_data;
    logic              loader_sram_write_enable;

    modport master (
        output pix_valid, pix_data,
        input  pix_ready, loader_sram_write_address, loader_sram_write_data,
               loader_sram_write_enable
    );

    modport slave (
        input  pix_valid, pix_data,
        output pix_ready, loader_sram_write_address, loader_sram_write_data,
               loader_sram_write_enable
    );
endinterface

// File: rtl/input_image_loader_row_packer.sv
// Assembles one row word from serial pixels; column c lands at bit c.
module input_image_loader_row_packer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic              pix_i,
    input  logic [4:0]        ncols_i,
    output logic [DATA_W-1:0] row_word_o,
    output logic              last_o
);
    localparam int COL_W = $clog2(DATA_W);

    logic [COL_W-1:0]  col_q;
    logic [DATA_W-1:0] row_q;
    logic [DATA_W-1:0] row_d;
    logic [DATA_W-1:0] mask;

    // row_word_o already includes the pixel being accepted this cycle
    always_comb begin
        row_d        = row_q;
        row_d[col_q] = pix_i;
        for (int i = 0; i < DATA_W; i++) begin
            mask[i] = (i < int'(ncols_i));
        end
        row_word_o = row_d & mask;
        last_o     = (int'(col_q) == int'(ncols_i) - 1);
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            col_q <= '0;
        end else if (accept_i) begin
            col_q <= col_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            row_q <= '0;
        end else if (accept_i) begin
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/input_image_loader.sv
// Writes image headers, packed row words and the terminator into input SRAM.
module input_image_loader
    import input_image_loader_pkg::*;
#(
    parameter int                ADDR_W    = IIL_ADDR_W,
    parameter int                DATA_W    = IIL_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [DATA_W-1:0] TERM_WORD = IIL_TERM_WORD
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 start,
    input  logic [4:0]           img_nrows,
    input  logic [4:0]           img_ncols,
    input  logic                 finish,
    input_image_loader_if.slave  bus,
    output logic                 loader_busy,
    output logic                 image_done,
    output logic                 dim_error,
    output logic                 addr_overflow
);
    localparam int ROW_W = $clog2(DATA_W);

    loader_state_e     state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              derr_q;
    logic              ovf_q;
    logic [4:0]        nrows_q;
    logic [4:0]        ncols_q;
    logic [ROW_W-1:0]  row_cnt_q;

    logic              accept;
    logic              pk_clear;
    logic              pk_last;
    logic [DATA_W-1:0] pk_word;

    assign ptr_d    = ptr_q + 1'b1;
    assign accept   = bus.pix_valid & ready_q;
    assign pk_clear = (state_q == ST_HDR_C) || (state_q == ST_ROW_WR);

    input_image_loader_row_packer #(.DATA_W(DATA_W)) u_packer (
        .clk        (clk),
        .rst        (reset_b),
        .clear_i    (pk_clear),
        .accept_i   (accept),
        .pix_i      (bus.pix_data),
        .ncols_i    (ncols_q),
        .row_word_o (pk_word),
        .last_o     (pk_last)
    );

    // Write strobe/address/data are loaded on entry to the writing state, so
    // each word is visible on the bus during the state that owns it.
    always_ff @(posedge clk) begin
        if (reset_b) begin
            state_q   <= ST_IDLE;
            ptr_q     <= BASE_ADDR;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            derr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            nrows_q   <= '0;
            ncols_q   <= '0;
            row_cnt_q <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            derr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (dim_ok(img_nrows) && dim_ok(img_ncols)) begin
                            nrows_q <= img_nrows;
                            ncols_q <= img_ncols;
                            state_q <= ST_HDR_R;
                            busy_q  <= 1'b1;
                            we_q    <= 1'b1;
                            addr_q  <= ptr_q;
                            wdata_q <= {{(DATA_W-5){1'b0}}, img_nrows};
                            ptr_q   <= ptr_d;
                            if (&ptr_q) ovf_q <= 1'b1;
                        end else begin
                            derr_q <= 1'b1;
                        end
                    end else if (finish) begin
                        state_q <= ST_TERM;
                        busy_q  <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= ptr_q;
                        wdata_q <= TERM_WORD;
                        ptr_q   <= ptr_d;
                        if (&ptr_q) ovf_q <= 1'b1;
                    end
                end
                ST_HDR_R: begin
                    state_q <= ST_HDR_C;
                    we_q    <= 1'b1;
                    addr_q  <= ptr_q;
                    wdata_q <= {{(DATA_W-5){1'b0}}, ncols_q};
                    ptr_q   <= ptr_d;
                    if (&ptr_q) ovf_q <= 1'b1;
                end
                ST_HDR_C: begin
                    state_q   <= ST_STREAM;
                    ready_q   <= 1'b1;
                    row_cnt_q <= '0;
                end
                ST_STREAM: begin
                    if (accept && pk_last) begin
                        state_q <= ST_ROW_WR;
                        ready_q <= 1'b0;
                        we_q    <= 1'b1;
                        addr_q  <= ptr_q;
                        wdata_q <= pk_word;
                        ptr_q   <= ptr_d;
                        if (&ptr_q) ovf_q <= 1'b1;
                    end
                end
                ST_ROW_WR: begin
                    row_cnt_q <= row_cnt_q + 1'b1;
                    if (int'(row_cnt_q) == int'(nrows_q) - 1) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_STREAM;
                        ready_q <= 1'b1;
                    end
                end
                ST_DONE, ST_TERM: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pix_ready                 = ready_q;
    assign bus.loader_sram_write_address = addr_q;
    assign bus.loader_sram_write_data    = wdata_q;
    assign bus.loader_sram_write_enable  = we_q;
    assign loader_busy                   = busy_q;
    assign image_done                    = done_q;
    assign dim_error                     = derr_q;
    assign addr_overflow                 = ovf_q;

endmodule
